// File: rtl/uga_uart_rx.sv
// uga_uart_rx: 8-bit UART receiver with optional even/odd parity, 8x oversampled
// by an external tick. Define UGA_UART_RX_MAJORITY_EN to make every bit decision
// a 2-of-3 majority of the last three tick samples instead of a single sample.

package uga_uart_rx_pkg;
  typedef enum logic [1:0] {none, even, odd} parity_e;
endpackage

module uga_uart_rx
  import uga_uart_rx_pkg::*;
#(
  parameter parity_e parity = none
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  input  logic       rx_data_ack,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_busy
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e     state_q, state_d;
  logic [1:0] sync_q, sync_d;
  logic       rxd_s;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d;
  logic       pbit_err_q, pbit_err_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       valid_q, valid_d;
  logic       perr_q, perr_d;
  logic       ferr_q, ferr_d;
  logic       ovr_q, ovr_d;
  logic       bit_dec;
  logic       done;

  assign rxd_s = sync_q[1];

`ifdef UGA_UART_RX_MAJORITY_EN
  logic [2:0] hist_q, hist_d;

  // History of the line at each tick; hist_d already includes the current tick,
  // so at a sample tick it spans nominal-2, nominal-1 and nominal.
  always_comb begin
    hist_d = hist_q;
    if (tick) hist_d = {hist_q[1:0], rxd_s};
  end

  // History register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_q <= 3'b111;
    else        hist_q <= hist_d;
  end

  assign bit_dec = (hist_d[0] & hist_d[1]) | (hist_d[0] & hist_d[2]) | (hist_d[1] & hist_d[2]);
`else
  assign bit_dec = rxd_s;
`endif

  // Two-flop synchronizer input shift
  always_comb begin
    sync_d = {sync_q[0], uart_rxd};
  end

  // FSM next state and receive datapath; everything advances only on tick
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    pbit_err_d = pbit_err_q;
    done       = 1'b0;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rxd_s) begin
            state_d    = S_START;
            cnt_d      = 3'd0;
            bitcnt_d   = 3'd0;
            pbit_err_d = 1'b0;
          end
        end
        S_START: begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd3) begin
            // Start bit centre: still low means a real frame, high means a glitch
            if (!bit_dec) begin
              state_d = S_DATA;
              cnt_d   = 3'd0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_DATA: begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            shift_d  = {bit_dec, shift_q[7:1]};
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) state_d = (parity == none) ? S_STOP : S_PARITY;
          end
        end
        S_PARITY: begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            pbit_err_d = (parity == odd) ? ~((^shift_q) ^ bit_dec) : ((^shift_q) ^ bit_dec);
            state_d    = S_STOP;
          end
        end
        S_STOP: begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output holding register, valid handshake and sticky overrun.
  // A completion that coincides with an ack is neither an overrun nor a clear.
  always_comb begin
    rx_data_d = rx_data_q;
    valid_d   = valid_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    ovr_d     = ovr_q;
    if (done) begin
      rx_data_d = shift_q;
      perr_d    = (parity == none) ? 1'b0 : pbit_err_q;
      ferr_d    = ~bit_dec;
      valid_d   = 1'b1;
      if (valid_q && !rx_data_ack) ovr_d = 1'b1;
    end else if (rx_data_ack && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  // State and data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= 2'b11;
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      bitcnt_q   <= 3'd0;
      shift_q    <= 8'h00;
      pbit_err_q <= 1'b0;
      rx_data_q  <= 8'h00;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      pbit_err_q <= pbit_err_d;
      rx_data_q  <= rx_data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_data_valid = valid_q;
  assign rx_parity_err = perr_q;
  assign rx_frame_err  = ferr_q;
  assign rx_overrun    = ovr_q;
  assign rx_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uga_uart_rx.sv
// tb_uga_uart_rx: scoreboard bench for uga_uart_rx, one instance without parity
// and one with even parity, each on its own serial line, sharing clk/tick/reset.

module tb_uga_uart_rx;
  import uga_uart_rx_pkg::*;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic       clk, rst_n, tick;
  logic       rxd_n, rxd_e, ack_n, ack_e;
  logic [7:0] data_n, data_e;
  logic       valid_n, valid_e, perr_n, perr_e, ferr_n, ferr_e;
  logic       ovr_n, ovr_e, busy_n, busy_e;

  uga_uart_rx #(.parity(none)) u_dut_n (
    .clk(clk), .rst_n(rst_n), .tick(tick), .uart_rxd(rxd_n),
    .rx_data(data_n), .rx_data_valid(valid_n), .rx_data_ack(ack_n),
    .rx_parity_err(perr_n), .rx_frame_err(ferr_n), .rx_overrun(ovr_n), .rx_busy(busy_n)
  );

  uga_uart_rx #(.parity(even)) u_dut_e (
    .clk(clk), .rst_n(rst_n), .tick(tick), .uart_rxd(rxd_e),
    .rx_data(data_e), .rx_data_valid(valid_e), .rx_data_ack(ack_e),
    .rx_parity_err(perr_e), .rx_frame_err(ferr_e), .rx_overrun(ovr_e), .rx_busy(busy_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  bit   cur_e;
  bit   m_valid[2];
  bit   m_ovr[2];

  logic [7:0] g_data;
  logic       g_valid, g_perr, g_ferr, g_ovr, g_busy;
  assign g_data  = cur_e ? data_e  : data_n;
  assign g_valid = cur_e ? valid_e : valid_n;
  assign g_perr  = cur_e ? perr_e  : perr_n;
  assign g_ferr  = cur_e ? ferr_e  : ferr_n;
  assign g_ovr   = cur_e ? ovr_e   : ovr_n;
  assign g_busy  = cur_e ? busy_e  : busy_n;

  // Count rising edges of valid on the no-parity instance
  int   rises_n = 0;
  logic valid_n_d = 1'b0;
  always @(negedge clk) begin
    if (valid_n && !valid_n_d) rises_n = rises_n + 1;
    valid_n_d = valid_n;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_line(input logic v);
    if (cur_e) rxd_e = v; else rxd_n = v;
  endtask

  task automatic set_ack(input logic v);
    if (cur_e) ack_e = v; else ack_n = v;
  endtask

  // Completion of a frame: pop expected byte, advance the handshake model, compare
  task automatic score(input logic ack_now);
    exp_t e;
    chk("sb_nonempty", (sb.size() > 0), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    if (m_valid[cur_e] && !ack_now) m_ovr[cur_e] = 1'b1;
    m_valid[cur_e] = 1'b1;
    chk("rx_data",  g_data,  e.data);
    chk("valid",    g_valid, m_valid[cur_e]);
    chk("perr",     g_perr,  e.perr);
    chk("ferr",     g_ferr,  e.ferr);
    chk("overrun",  g_ovr,   m_ovr[cur_e]);
    chk("busy_end", g_busy,  0);
  endtask

  // One tick period = 4 clks, tick high for the first
  task automatic do_tick(input logic v, input logic ack_now, input bit at_done);
    set_line(v);
    set_ack(ack_now);
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    set_ack(1'b0);
    if (at_done) score(ack_now);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_tick(1'b1, 1'b0, 1'b0);
  endtask

  // Stop bit is sampled at tick 5 of its 8 (start detect 1 tick late, centre at cnt 3/7)
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopb,
                            input bit ack_done, input int abort_at);
    exp_t e;
    int   nb;
    int   idx;
    logic v;
    e.data = d;
    e.perr = cur_e ? ((^d) ^ pbit) : 1'b0;
    e.ferr = ~stopb;
    sb.push_back(e);
    nb  = cur_e ? 11 : 10;
    idx = 0;
    for (int b = 0; b < nb; b++) begin
      if (b == 0)              v = 1'b0;
      else if (b <= 8)         v = d[b-1];
      else if (b == nb - 1)    v = stopb;
      else                     v = pbit;
      for (int o = 0; o < 8; o++) begin
        if (idx == abort_at) begin
          sb.delete(sb.size() - 1);
          return;
        end
        do_tick(v, (b == nb - 1 && o == 5) ? ack_done : 1'b0, (b == nb - 1 && o == 5));
        if (b == 2 && o == 0) chk("busy_mid", g_busy, 1);
        idx++;
      end
    end
    set_line(1'b1);
  endtask

  task automatic do_ack();
    set_ack(1'b1);
    @(posedge clk); #1;
    set_ack(1'b0);
    if (m_valid[cur_e]) begin
      m_valid[cur_e] = 1'b0;
      m_ovr[cur_e]   = 1'b0;
    end
    chk("ack_valid", g_valid, m_valid[cur_e]);
    chk("ack_ovr",   g_ovr,   m_ovr[cur_e]);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_data"},  g_data,  0);
    chk({tag, "_valid"}, g_valid, 0);
    chk({tag, "_perr"},  g_perr,  0);
    chk({tag, "_ferr"},  g_ferr,  0);
    chk({tag, "_ovr"},   g_ovr,   0);
    chk({tag, "_busy"},  g_busy,  0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   snap;
    logic [7:0] d;
    logic pb;
    rst_n = 1'b0; tick = 1'b0;
    rxd_n = 1'b1; rxd_e = 1'b1; ack_n = 1'b0; ack_e = 1'b0;
    cur_e = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cur_e = 1'b0; chk_reset_outs("rst_n");
    cur_e = 1'b1; chk_reset_outs("rst_e");
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // No parity: 0x55, then ack clears valid, ack with valid low is harmless
    cur_e = 1'b0;
    idle(4);
    send_frame(8'h55, 1'b0, 1'b1, 1'b0, -1);
    do_ack();
    do_ack();

    // Even parity: 0xA3 has even weight, so parity bit 1 is an error, 0 is not
    cur_e = 1'b1;
    idle(4);
    send_frame(8'hA3, 1'b1, 1'b1, 1'b0, -1);
    do_ack();
    send_frame(8'hA3, 1'b0, 1'b1, 1'b0, -1);
    do_ack();

    // Frame error delivered, then a clean byte
    cur_e = 1'b0;
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, -1);
    do_ack();
    idle(16);
    chk("ferr_recover_busy", g_busy, 0);
    send_frame(8'h12, 1'b0, 1'b1, 1'b0, -1);
    do_ack();

    // Start glitch: low for two ticks only
    snap = rises_n;
    do_tick(1'b0, 1'b0, 1'b0);
    do_tick(1'b0, 1'b0, 1'b0);
    chk("glitch_busy", g_busy, 1);
    idle(14);
    chk("glitch_idle",  g_busy,  0);
    chk("glitch_valid", g_valid, 0);
    chk("glitch_rises", rises_n - snap, 0);

    // Overrun, then ack coinciding with completion
    send_frame(8'h01, 1'b0, 1'b1, 1'b0, -1);
    send_frame(8'h02, 1'b0, 1'b1, 1'b0, -1);
    send_frame(8'h03, 1'b0, 1'b1, 1'b1, -1);
    do_ack();

    // Random even-parity traffic with random parity bits
    cur_e = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d  = 8'($urandom);
      pb = 1'($urandom_range(0, 1));
      send_frame(d, pb, 1'b1, 1'b0, -1);
      do_ack();
    end

    // Reset during bit 4 with a byte pending, then only 0x3C must appear
    cur_e = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, -1);
    snap = rises_n;
    send_frame(8'hC3, 1'b0, 1'b1, 1'b0, 43);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midrst");
    m_valid[0] = 1'b0; m_ovr[0] = 1'b0;
    m_valid[1] = 1'b0; m_ovr[1] = 1'b0;
    set_line(1'b1);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(16);
    chk("post_rst_busy", g_busy, 0);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, -1);
    idle(4);
    chk("post_rst_rises", rises_n - snap, 1);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uga_uart_rx.md
UGA_UART_RX -- requirements
Module: uga_uart_rx

Interface
REQ-001 SHALL have parameter: parity, none, enum {none,even,odd} selecting the expected parity bit after the payload.
REQ-002 SHALL have port: clk  input  1  system clock; every register samples on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port: tick  input  1  one-clk pulse at 8x baud rate; this is the same tick that drives the transmitter.
REQ-005 SHALL have port: uart_rxd  input  1  serial line; idles high; asynchronous to clk.
REQ-006 SHALL have port: rx_data  output  8  last received byte, LSB received first.
REQ-007 SHALL have port: rx_data_valid  output  1  high while rx_data holds an unread byte.
REQ-008 SHALL have port: rx_data_ack  input  1  consumer read strobe; clears rx_data_valid.
REQ-009 SHALL have port: rx_parity_err  output  1  parity mismatch for the byte in rx_data; always 0 when parity==none.
REQ-010 SHALL have port: rx_frame_err  output  1  stop bit sampled low for the byte in rx_data.
REQ-011 SHALL have port: rx_overrun  output  1  sticky flag: a byte was completed while rx_data_valid was high.
REQ-012 SHALL have port: rx_busy  output  1  high when the FSM is not in IDLE.

Function
REQ-013 SHALL pass uart_rxd through a 2-flop synchronizer that resets to 1; all logic uses the synchronized value (rxd_s).
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; the FSM advances only on tick.
REQ-015 IDLE: on a tick with rxd_s==0, SHALL go to START and clear the 3-bit sample counter cnt.
REQ-016 START: cnt SHALL increment on each tick; on the tick where cnt==3, the FSM SHALL sample rxd_s.
- If the sample is 0: go to DATA and set cnt=0.
- If the sample is 1 (false start / glitch): return to IDLE.
REQ-017 DATA/PARITY/STOP: cnt SHALL increment modulo 8 on each tick; a bit is sampled on the tick where cnt==7, i.e. at bit centre.
REQ-018 DATA SHALL shift each sampled bit into bit 7 of an 8-bit shift register (right shift), using a 3-bit bit counter.
- After the 8th bit: go to PARITY if parity!=none, otherwise go to STOP.
REQ-019 PARITY SHALL sample one bit and compute the error as follows; the FSM then goes to STOP.
- Even parity: error = (^data) ^ bit.
- Odd parity: error = ~((^data) ^ bit).
REQ-020 STOP SHALL sample the stop bit and return to IDLE on the same tick.
- A new start is not recognised until the next tick that sees rxd_s==0 in IDLE.
REQ-021 On the STOP sample clk cycle, the block SHALL do all of the following together:
- Load rx_data from the shift register.
- Load rx_parity_err and rx_frame_err (frame error = sampled stop bit ==0).
- Set rx_data_valid.
REQ-022 Latency SHALL be: rx_data_valid rises one clk after the tick at which the stop bit is sampled.
REQ-023 rx_data_ack with rx_data_valid high SHALL clear rx_data_valid on the next clk; rx_data_ack with rx_data_valid low SHALL have no effect.
REQ-024 Simultaneous ack and byte completion: the new byte SHALL be loaded, rx_data_valid SHALL stay 1, and rx_overrun SHALL NOT be set.
REQ-025 Byte completion while rx_data_valid is high and no ack: the new byte SHALL overwrite rx_data and its error flags, and rx_overrun SHALL be set.
REQ-026 rx_overrun SHALL clear only on reset or on an rx_data_ack cycle that is not itself an overrun cycle.
REQ-027 A frame-error byte SHALL still be delivered; the FSM returns to IDLE and requires rxd_s==0 on a later tick to restart.
REQ-028 rx_busy SHALL be combinational: (state != IDLE).

Reset
REQ-029 rst_n low SHALL immediately (asynchronously) set the following:
- FSM = IDLE; cnt, bit counter and shift register = 0; synchronizer flops = 1.
- rx_data = 8'h00; rx_data_valid, rx_parity_err, rx_frame_err, rx_overrun = 0.
REQ-030 Deassertion of rst_n mid-frame SHALL resume from IDLE; any partial frame is discarded and no rx_data_valid is generated for it.

Configuration
REQ-031 With macro UGA_UART_RX_MAJORITY_EN defined, every bit decision in START, DATA, PARITY and STOP SHALL be the 2-of-3 majority of rxd_s sampled on the ticks where cnt equals the nominal sample value -2, -1 and 0. These samples are captured in a 3-bit history register.
REQ-032 Without UGA_UART_RX_MAJORITY_EN, each bit decision SHALL be the single rxd_s value at the sample tick; the history register SHALL NOT exist.

Verification
REQ-033 parity=none, 8'h55 sent with a valid stop bit -> rx_data=8'h55, valid pulse, both error flags 0; ack clears rx_data_valid on the next clk.
REQ-034 parity=even, 8'hA3 sent with parity bit 1 -> rx_parity_err=1; the same byte with parity bit 0 -> rx_parity_err=0.
REQ-035 8'hFF sent with stop bit 0 -> rx_frame_err=1 and rx_data=8'hFF; a following 8'h12 with a good stop bit is received cleanly.
REQ-036 uart_rxd low for 2 ticks then high (glitch) -> FSM returns to IDLE and rx_data_valid stays 0.
REQ-037 Overrun: 8'h01 then 8'h02 back-to-back with no ack -> rx_data=8'h02 and rx_overrun=1. Next, ack on the same clk as completion of 8'h03 -> rx_data_valid=1 and rx_overrun unchanged.
REQ-038 Reset: assert rst_n low during bit 4 of a frame -> all outputs immediately 0. Then release rst_n and send 8'h3C -> only 8'h3C is reported.
